legv8_control_fsm: RTL and testbench

Multi-cycle control unit that drives the LEGv8 datapath. It latches a 32-bit instruction, decodes it, and sequences the 25-bit datapath control word, the 64-bit constant, program-counter select, status-load and instruction-load strobes. It consumes the datapath's 5-bit status return. It sits between the instruction ROM and program counter on one side and the datapath on the other.

---
 rtl/legv8_pkg.sv | 97 +++++++++
 rtl/legv8_cond_eval.sv | 34 +++
 rtl/legv8_control_fsm.sv | 127 ++++++++++++
 tb/tb_legv8_control_fsm.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/legv8_pkg.sv
// Shared constants, types and decode helpers for the LEGv8 multi-cycle control unit.
package legv8_pkg;

    localparam logic [4:0] FS_AND = 5'b00000;
    localparam logic [4:0] FS_ORR = 5'b00100;
    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_SUB = 5'b01011;
    localparam logic [4:0] FS_EOR = 5'b01100;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_EOR  = 11'b11001010000;
    localparam logic [10:0] OP_ADDS = 11'b10101011000;
    localparam logic [10:0] OP_SUBS = 11'b11101011000;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI = 10'b1101000100;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ = 8'b10110101;
    localparam logic [7:0]  OP_BCOND = 8'b01010100;
    localparam logic [5:0]  OP_B    = 6'b000101;

    localparam logic [1:0] PS_HOLD   = 2'b00;
    localparam logic [1:0] PS_INC    = 2'b01;
    localparam logic [1:0] PS_BRANCH = 2'b10;

    localparam logic [3:0] COND_EQ = 4'b0000, COND_NE = 4'b0001;
    localparam logic [3:0] COND_HS = 4'b0010, COND_LO = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100, COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110, COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000, COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010, COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100, COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        MEM   = 2'd2
    } state_t;

    typedef enum logic [3:0] {
        I_ADD, I_SUB, I_AND, I_ORR, I_EOR, I_ADDS, I_SUBS,
        I_ADDI, I_SUBI, I_STUR, I_LDUR, I_B, I_CBZ, I_CBNZ, I_BCOND, I_ILLEGAL
    } instr_t;

    // Packs MSB-first into the 25-bit datapath control word.
    typedef struct packed {
        logic [4:0] sa;
        logic [4:0] sb;
        logic [4:0] da;
        logic       reg_write;
        logic       mem_write;
        logic [4:0] fs;
        logic       bsel;
        logic       en_mem;
        logic       en_alu;
    } ctrl_word_t;

    // Widest-opcode-first so the shorter branch prefixes never shadow a data op.
    function automatic instr_t decode(input logic [10:0] opc);
        instr_t op;
        op = I_ILLEGAL;
        if      (opc == OP_ADD)       op = I_ADD;
        else if (opc == OP_SUB)       op = I_SUB;
        else if (opc == OP_AND)       op = I_AND;
        else if (opc == OP_ORR)       op = I_ORR;
        else if (opc == OP_EOR)       op = I_EOR;
        else if (opc == OP_ADDS)      op = I_ADDS;
        else if (opc == OP_SUBS)      op = I_SUBS;
        else if (opc == OP_STUR)      op = I_STUR;
        else if (opc == OP_LDUR)      op = I_LDUR;
        else if (opc[10:1] == OP_ADDI) op = I_ADDI;
        else if (opc[10:1] == OP_SUBI) op = I_SUBI;
        else if (opc[10:3] == OP_CBZ)  op = I_CBZ;
        else if (opc[10:3] == OP_CBNZ) op = I_CBNZ;
        else if (opc[10:3] == OP_BCOND) op = I_BCOND;
        else if (opc[10:5] == OP_B)    op = I_B;
        return op;
    endfunction

    function automatic logic [4:0] alu_fs(input instr_t op);
        logic [4:0] fs;
        case (op)
            I_SUB, I_SUBS, I_SUBI: fs = FS_SUB;
            I_AND:                 fs = FS_AND;
            I_ORR:                 fs = FS_ORR;
            I_EOR:                 fs = FS_EOR;
            default:               fs = FS_ADD;
        endcase
        return fs;
    endfunction

endpackage

// File: rtl/legv8_cond_eval.sv
// Evaluates a B.cond condition code against the latched {V,C,N,Z} flags.
module legv8_cond_eval
    import legv8_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       taken
);

    logic v, c, n, z;
    logic base;

    assign v = flags[3];
    assign c = flags[2];
    assign n = flags[1];
    assign z = flags[0];

    // Even codes define the test; odd codes invert it, except the AL pair.
    always_comb begin
        base = 1'b1;
        case (cond[3:1])
            COND_EQ[3:1]: base = z;
            COND_HS[3:1]: base = c;
            COND_MI[3:1]: base = n;
            COND_VS[3:1]: base = v;
            COND_HI[3:1]: base = c & ~z;
            COND_GE[3:1]: base = (n == v);
            COND_GT[3:1]: base = ~z & (n == v);
            default:      base = 1'b1;
        endcase
        taken = (cond[0] && (cond[3:1] != COND_AL[3:1])) ? ~base : base;
    end

endmodule

// File: rtl/legv8_control_fsm.sv
// Multi-cycle LEGv8 control unit: FETCH latches IR, EXEC decodes, MEM finishes LDUR.
module legv8_control_fsm
    import legv8_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic [4:0]  status,
    output logic [24:0] ControlWord,
    output logic [63:0] K,
    output logic [1:0]  PS,
    output logic        IL,
    output logic        SL,
    output logic        illegal,
    output state_t      fsm_state
);

    state_t     state, state_next;
    logic [31:0] ir;
    instr_t     op;
    ctrl_word_t cw;
    logic       cond_taken;
    logic [4:0] rd, rn, rm;
    logic [63:0] imm12_zx, imm9_sx, imm19_sx, imm26_sx;

    assign op        = decode(ir[31:21]);
    assign rd        = ir[4:0];
    assign rn        = ir[9:5];
    assign rm        = ir[20:16];
    assign imm12_zx  = {52'd0, ir[21:10]};
    assign imm9_sx   = {{55{ir[20]}}, ir[20:12]};
    assign imm19_sx  = {{45{ir[23]}}, ir[23:5]};
    assign imm26_sx  = {{38{ir[25]}}, ir[25:0]};
    assign fsm_state = state;
    assign ControlWord = cw;

    legv8_cond_eval u_cond_eval (
        .cond  (ir[3:0]),
        .flags (status[4:1]),
        .taken (cond_taken)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= FETCH;
            ir    <= '0;
        end else begin
            state <= state_next;
            if (state == FETCH) ir <= instruction;
        end
    end

    // Reset forces the NOP word so an interrupted EXEC/MEM never writes.
    always_comb begin
        cw         = '{sa: 5'd31, sb: 5'd31, da: 5'd31, reg_write: 1'b0, mem_write: 1'b0,
                       fs: FS_ADD, bsel: 1'b0, en_mem: 1'b0, en_alu: 1'b0};
        K          = '0;
        PS         = PS_HOLD;
        IL         = 1'b0;
        SL         = 1'b0;
        illegal    = 1'b0;
        state_next = FETCH;
        if (!reset) begin
            case (state)
                FETCH: begin
                    IL         = 1'b1;
                    state_next = EXEC;
                end
                EXEC: begin
                    case (op)
                        I_ADD, I_SUB, I_AND, I_ORR, I_EOR, I_ADDS, I_SUBS, I_ADDI, I_SUBI: begin
                            cw.sa        = rn;
                            cw.sb        = rm;
                            cw.da        = rd;
                            cw.reg_write = 1'b1;
                            cw.en_alu    = 1'b1;
                            cw.fs        = alu_fs(op);
                            SL           = (op == I_ADDS) || (op == I_SUBS);
                            PS           = PS_INC;
                            if (op == I_ADDI || op == I_SUBI) begin
                                cw.bsel = 1'b1;
                                K       = imm12_zx;
                            end
                        end
                        I_STUR, I_LDUR: begin
                            cw.sa        = rn;
                            cw.sb        = rd;
                            cw.bsel      = 1'b1;
                            K            = imm9_sx;
                            cw.mem_write = (op == I_STUR);
                            PS           = (op == I_STUR) ? PS_INC : PS_HOLD;
                            state_next   = (op == I_LDUR) ? MEM : FETCH;
                        end
                        I_B: begin
                            K  = imm26_sx;
                            PS = PS_BRANCH;
                        end
                        I_CBZ, I_CBNZ: begin
                            cw.sb = rd;
                            K     = imm19_sx;
                            PS    = ((op == I_CBZ) == status[0]) ? PS_BRANCH : PS_INC;
                        end
                        I_BCOND: begin
                            K  = imm19_sx;
                            PS = cond_taken ? PS_BRANCH : PS_INC;
                        end
                        default: begin
                            PS      = PS_INC;
                            illegal = 1'b1;
                        end
                    endcase
                end
                MEM: begin
                    cw.sa        = rn;
                    cw.da        = rd;
                    cw.bsel      = 1'b1;
                    cw.en_mem    = 1'b1;
                    cw.reg_write = 1'b1;
                    K            = imm9_sx;
                    PS           = PS_INC;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_legv8_control_fsm.sv
// Cycle-accurate checks of the LEGv8 control unit against hand-decoded expectations.
module tb_legv8_control_fsm;

    localparam logic [4:0] T_AND = 5'b00000;
    localparam logic [4:0] T_ORR = 5'b00100;
    localparam logic [4:0] T_ADD = 5'b01000;
    localparam logic [4:0] T_SUB = 5'b01011;
    localparam logic [4:0] T_EOR = 5'b01100;

    typedef struct packed {
        logic        rst;
        logic [31:0] w;
        logic [4:0]  st;
    } cyc_t;

    logic        clock;
    logic        reset;
    logic [31:0] instruction;
    logic [4:0]  status;
    logic [24:0] ControlWord;
    logic [63:0] K;
    logic [1:0]  PS;
    logic        IL, SL, illegal;
    logic [1:0]  fsm_state;

    logic [95:0] exp_q[$];
    cyc_t        cyc_q[$];
    int          n_run = 0;
    int          n_fail = 0;

    legv8_control_fsm dut (
        .clock       (clock),
        .reset       (reset),
        .instruction (instruction),
        .status      (status),
        .ControlWord (ControlWord),
        .K           (K),
        .PS          (PS),
        .IL          (IL),
        .SL          (SL),
        .illegal     (illegal),
        .fsm_state   (fsm_state)
    );

    // ---- clock / reset ----
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // {state, SA, SB, DA, RegWrite, MemWrite, FS, Bsel, EN_Mem, EN_ALU, K, PS, IL, SL, illegal}
    function automatic logic [95:0] mk(input logic [1:0] st, input logic [4:0] sa, input logic [4:0] sb,
                                       input logic [4:0] da, input logic rw, input logic mw,
                                       input logic [4:0] fs, input logic bsel, input logic enm,
                                       input logic ena, input logic [63:0] k, input logic [1:0] ps,
                                       input logic il, input logic sl, input logic ill);
        return {st, sa, sb, da, rw, mw, fs, bsel, enm, ena, k, ps, il, sl, ill};
    endfunction

    function automatic logic [95:0] fetch_exp();
        return mk(2'd0, 5'd31, 5'd31, 5'd31, 1'b0, 1'b0, T_ADD, 1'b0, 1'b0, 1'b0, 64'd0, 2'b00, 1'b1, 1'b0, 1'b0);
    endfunction

    function automatic logic [95:0] nop_exp(input logic [1:0] st, input logic [63:0] k,
                                            input logic [1:0] ps, input logic ill);
        return mk(st, 5'd31, 5'd31, 5'd31, 1'b0, 1'b0, T_ADD, 1'b0, 1'b0, 1'b0, k, ps, 1'b0, 1'b0, ill);
    endfunction

    // ---- driver tasks ----
    task automatic add_cycle(input logic rst, input logic [31:0] w, input logic [4:0] st, input logic [95:0] e);
        cyc_q.push_back('{rst: rst, w: w, st: st});
        exp_q.push_back(e);
    endtask

    task automatic drive_cycle(input cyc_t c, output logic [95:0] got);
        @(negedge clock);
        reset       = c.rst;
        instruction = c.w;
        status      = c.st;
        #1;
        got = {fsm_state, ControlWord, K, PS, IL, SL, illegal};
    endtask

    // Queue a two-cycle instruction: FETCH with the word on the bus, EXEC with junk on the bus.
    task automatic add_instr(input logic [31:0] w, input logic [4:0] st, input logic [95:0] e_exec);
        add_cycle(1'b0, w, 5'($urandom_range(0, 31)), fetch_exp());
        add_cycle(1'b0, $urandom, st, e_exec);
    endtask

    // ---- scenarios ----
    task automatic test_reset();
        logic [95:0] got, e;
        add_cycle(1'b1, 32'h8B020023, 5'd0, nop_exp(2'd0, 64'd0, 2'b00, 1'b0));
        add_cycle(1'b1, 32'hFFFFFFFF, 5'd31, nop_exp(2'd0, 64'd0, 2'b00, 1'b0));
        while (exp_q.size() > 0) begin
            drive_cycle(cyc_q.pop_front(), got);
            e = exp_q.pop_front();
            n_run++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL reset: got %h expected %h", got, e);
            end
        end
    endtask

    task automatic test_alu_back_to_back();
        logic [95:0] got, e;
        int cyc = 0;
        add_instr(32'h8B020023, 5'($urandom_range(0, 31)),
                  mk(2'd1, 5'd1, 5'd2, 5'd3, 1, 0, T_ADD, 0, 0, 1, 64'd0, 2'b01, 0, 0, 0));
        add_instr(32'h913FFC05, 5'($urandom_range(0, 31)),
                  mk(2'd1, 5'd0, 5'd31, 5'd5, 1, 0, T_ADD, 1, 0, 1, 64'h0000_0000_0000_0FFF, 2'b01, 0, 0, 0));
        add_instr(32'hEB020021, 5'($urandom_range(0, 31)),
                  mk(2'd1, 5'd1, 5'd2, 5'd1, 1, 0, T_SUB, 0, 0, 1, 64'd0, 2'b01, 0, 1, 0));
        add_instr(32'h8A0600A4, 5'($urandom_range(0, 31)),
                  mk(2'd1, 5'd5, 5'd6, 5'd4, 1, 0, T_AND, 0, 0, 1, 64'd0, 2'b01, 0, 0, 0));
        add_instr(32'hAA090107, 5'($urandom_range(0, 31)),
                  mk(2'd1, 5'd8, 5'd9, 5'd7, 1, 0, T_ORR, 0, 0, 1, 64'd0, 2'b01, 0, 0, 0));
        add_instr(32'hCA0C016A, 5'($urandom_range(0, 31)),
                  mk(2'd1, 5'd11, 5'd12, 5'd10, 1, 0, T_EOR, 0, 0, 1, 64'd0, 2'b01, 0, 0, 0));
        add_instr(32'hCB040062, 5'($urandom_range(0, 31)),
                  mk(2'd1, 5'd3, 5'd4, 5'd2, 1, 0, T_SUB, 0, 0, 1, 64'd0, 2'b01, 0, 0, 0));
        add_instr(32'hAB020020, 5'($urandom_range(0, 31)),
                  mk(2'd1, 5'd1, 5'd2, 5'd0, 1, 0, T_ADD, 0, 0, 1, 64'd0, 2'b01, 0, 1, 0));
        add_instr(32'hD10004E6, 5'($urandom_range(0, 31)),
                  mk(2'd1, 5'd7, 5'd0, 5'd6, 1, 0, T_SUB, 1, 0, 1, 64'd1, 2'b01, 0, 0, 0));
        while (exp_q.size() > 0) begin
            drive_cycle(cyc_q.pop_front(), got);
            e = exp_q.pop_front();
            n_run++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL alu cycle %0d: got %h expected %h", cyc, got, e);
            end
            cyc++;
        end
    endtask

    task automatic test_mem();
        logic [95:0] got, e;
        int cyc = 0;
        add_instr(32'hF8010043, 5'($urandom_range(0, 31)),
                  mk(2'd1, 5'd2, 5'd3, 5'd31, 0, 1, T_ADD, 1, 0, 0, 64'd16, 2'b01, 0, 0, 0));
        add_instr(32'hF85F8044, 5'($urandom_range(0, 31)),
                  mk(2'd1, 5'd2, 5'd4, 5'd31, 0, 0, T_ADD, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFF8, 2'b00, 0, 0, 0));
        add_cycle(1'b0, $urandom, 5'($urandom_range(0, 31)),
                  mk(2'd2, 5'd2, 5'd31, 5'd4, 1, 0, T_ADD, 1, 1, 0, 64'hFFFF_FFFF_FFFF_FFF8, 2'b01, 0, 0, 0));
        add_cycle(1'b0, 32'h8B020023, 5'($urandom_range(0, 31)), fetch_exp());
        while (exp_q.size() > 0) begin
            drive_cycle(cyc_q.pop_front(), got);
            e = exp_q.pop_front();
            n_run++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL mem cycle %0d: got %h expected %h", cyc, got, e);
            end
            cyc++;
        end
        // The trailing FETCH above latched ADD; let its EXEC go by unchecked-free by checking it too.
        add_cycle(1'b0, $urandom, 5'd0, mk(2'd1, 5'd1, 5'd2, 5'd3, 1, 0, T_ADD, 0, 0, 1, 64'd0, 2'b01, 0, 0, 0));
        drive_cycle(cyc_q.pop_front(), got);
        e = exp_q.pop_front();
        n_run++;
        if (got !== e) begin
            n_fail++;
            $display("FAIL mem tail: got %h expected %h", got, e);
        end
    endtask

    task automatic test_branch();
        logic [95:0] got, e;
        int cyc = 0;
        add_instr(32'hB4FFFFC7, 5'b00001, mk(2'd1, 5'd31, 5'd7, 5'd31, 0, 0, T_ADD, 0, 0, 0,
                                             64'hFFFF_FFFF_FFFF_FFFE, 2'b10, 0, 0, 0));
        add_instr(32'hB4FFFFC7, 5'b11110, mk(2'd1, 5'd31, 5'd7, 5'd31, 0, 0, T_ADD, 0, 0, 0,
                                             64'hFFFF_FFFF_FFFF_FFFE, 2'b01, 0, 0, 0));
        add_instr(32'hB5FFFFC7, 5'b00000, mk(2'd1, 5'd31, 5'd7, 5'd31, 0, 0, T_ADD, 0, 0, 0,
                                             64'hFFFF_FFFF_FFFF_FFFE, 2'b10, 0, 0, 0));
        add_instr(32'hB5FFFFC7, 5'b00001, mk(2'd1, 5'd31, 5'd7, 5'd31, 0, 0, T_ADD, 0, 0, 0,
                                             64'hFFFF_FFFF_FFFF_FFFE, 2'b01, 0, 0, 0));
        add_instr(32'h17FFFFFF, 5'($urandom_range(0, 31)), nop_exp(2'd1, '1, 2'b10, 1'b0));
        while (exp_q.size() > 0) begin
            drive_cycle(cyc_q.pop_front(), got);
            e = exp_q.pop_front();
            n_run++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL branch cycle %0d: got %h expected %h", cyc, got, e);
            end
            cyc++;
        end
    endtask

    task automatic test_bcond();
        logic [95:0] got, e;
        int cyc = 0;
        // status = {V,C,N,Z, live Z}; the live Z bit is randomised since B.cond ignores it.
        add_instr(32'h5400006C, {4'b0000, 1'($urandom)}, nop_exp(2'd1, 64'd3, 2'b10, 1'b0));
        add_instr(32'h5400006C, {4'b0001, 1'($urandom)}, nop_exp(2'd1, 64'd3, 2'b01, 1'b0));
        add_instr(32'h5400006C, {4'b1010, 1'($urandom)}, nop_exp(2'd1, 64'd3, 2'b10, 1'b0));
        add_instr(32'h5400006C, {4'b1000, 1'($urandom)}, nop_exp(2'd1, 64'd3, 2'b01, 1'b0));
        add_instr(32'h54000040, {4'b0001, 1'($urandom)}, nop_exp(2'd1, 64'd2, 2'b10, 1'b0));
        add_instr(32'h54000043, {4'b0000, 1'($urandom)}, nop_exp(2'd1, 64'd2, 2'b10, 1'b0));
        add_instr(32'h54000049, {4'b0100, 1'($urandom)}, nop_exp(2'd1, 64'd2, 2'b01, 1'b0));
        add_instr(32'h5400004F, {4'($urandom_range(0, 15)), 1'($urandom)}, nop_exp(2'd1, 64'd2, 2'b10, 1'b0));
        while (exp_q.size() > 0) begin
            drive_cycle(cyc_q.pop_front(), got);
            e = exp_q.pop_front();
            n_run++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL bcond cycle %0d: got %h expected %h", cyc, got, e);
            end
            cyc++;
        end
    endtask

    task automatic test_illegal();
        logic [95:0] got, e;
        int cyc = 0;
        add_instr(32'hFFFFFFFF, 5'($urandom_range(0, 31)), nop_exp(2'd1, 64'd0, 2'b01, 1'b1));
        add_cycle(1'b0, 32'h8B020023, 5'($urandom_range(0, 31)), fetch_exp());
        add_cycle(1'b0, $urandom, 5'd0, mk(2'd1, 5'd1, 5'd2, 5'd3, 1, 0, T_ADD, 0, 0, 1, 64'd0, 2'b01, 0, 0, 0));
        while (exp_q.size() > 0) begin
            drive_cycle(cyc_q.pop_front(), got);
            e = exp_q.pop_front();
            n_run++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL illegal cycle %0d: got %h expected %h", cyc, got, e);
            end
            cyc++;
        end
    endtask

    task automatic test_reset_mid_instr();
        logic [95:0] got, e;
        int cyc = 0;
        // Reset while LDUR sits in EXEC, then again while a second LDUR sits in MEM.
        add_cycle(1'b0, 32'hF85F8044, 5'd0, fetch_exp());
        add_cycle(1'b1, $urandom, 5'd0, nop_exp(2'd1, 64'd0, 2'b00, 1'b0));
        add_cycle(1'b0, 32'hF85F8044, 5'd0, fetch_exp());
        add_cycle(1'b0, $urandom, 5'd0,
                  mk(2'd1, 5'd2, 5'd4, 5'd31, 0, 0, T_ADD, 1, 0, 0, 64'hFFFF_FFFF_FFFF_FFF8, 2'b00, 0, 0, 0));
        add_cycle(1'b1, $urandom, 5'd0, nop_exp(2'd2, 64'd0, 2'b00, 1'b0));
        add_cycle(1'b0, 32'hEB020021, 5'd0, fetch_exp());
        add_cycle(1'b0, $urandom, 5'd0, mk(2'd1, 5'd1, 5'd2, 5'd1, 1, 0, T_SUB, 0, 0, 1, 64'd0, 2'b01, 0, 1, 0));
        while (exp_q.size() > 0) begin
            drive_cycle(cyc_q.pop_front(), got);
            e = exp_q.pop_front();
            n_run++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL reset_mid cycle %0d: got %h expected %h", cyc, got, e);
            end
            cyc++;
        end
    endtask

    initial begin
        reset       = 1'b1;
        instruction = '0;
        status      = '0;
        repeat (2) @(posedge clock);
        test_reset();
        test_alu_back_to_back();
        test_mem();
        test_branch();
        test_bcond();
        test_illegal();
        test_reset_mid_instr();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
